// File: rtl/mem_bus_controller_if.sv
// CPU load/store port of the memory bus controller.
// The CPU drives request/address/data; the controller returns data, ready and error.
interface mem_bus_controller_if;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 32;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_write_value;
   logic [DATA_W-1:0] cpu_read_value;
   logic              cpu_ready;
   logic              bus_error;

   modport master (
      output cpu_req, cpu_we, cpu_address, cpu_write_value,
      input  cpu_read_value, cpu_ready, bus_error
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_address, cpu_write_value,
      output cpu_read_value, cpu_ready, bus_error
   );
endinterface

// File: rtl/mem_bus_controller.sv
// Routes CPU word accesses to block RAM or memory-mapped I/O (switches, buttons,
// accumulator), hides the RAM's one-cycle read latency and flags unmapped addresses.
module mem_bus_controller #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [19:0] IO_BASE   = 20'h01000,
   localparam int unsigned ADDR_W   = 20,
   localparam int unsigned DATA_W   = 32,
   localparam int unsigned SW_W     = 16,
   localparam int unsigned BTN_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_controller_if.slave cpu,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_value,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_read_value,
   input  logic [SW_W-1:0]   switches,
   input  logic [BTN_W-1:0]  buttons,
   output logic [DATA_W-1:0] accum_out
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      RAM_WAIT = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] maddr_d;
   logic [DATA_W-1:0] mwdata_d;
   logic              mwe_d;
   logic [DATA_W-1:0] accum_d;

   logic [SW_W-1:0]   sw_meta, sw_sync;
   logic [BTN_W-1:0]  btn_meta, btn_sync;

   logic [ADDR_W-1:0] io_off;
   logic              is_ram, is_io;

   // Address decode: unsigned compares on the full word address, no aliasing
   always_comb begin
      io_off = cpu.cpu_address - IO_BASE;
      is_ram = cpu.cpu_address < ADDR_W'(RAM_WORDS);
      is_io  = (cpu.cpu_address >= IO_BASE) && (io_off <= ADDR_W'(2));
   end

   // Next state and next register values
   always_comb begin
      state_d  = state_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      maddr_d  = mem_address;
      mwdata_d = mem_write_value;
      mwe_d    = 1'b0;
      accum_d  = accum_out;

      unique case (state_q)
         IDLE: begin
            if (cpu.cpu_req) begin
               if (is_ram) begin
                  maddr_d  = cpu.cpu_address;
                  mwdata_d = cpu.cpu_write_value;
                  mwe_d    = cpu.cpu_we;
                  state_d  = ACCESS;
               end else begin
                  state_d = DONE;
                  ready_d = 1'b1;
                  if (is_io) begin
                     if (!cpu.cpu_we) begin
                        unique case (io_off[1:0])
                           2'd0:    rdata_d = DATA_W'(sw_sync);
                           2'd1:    rdata_d = DATA_W'(btn_sync);
                           default: rdata_d = accum_out;
                        endcase
                     end else if (io_off[1:0] == 2'd2) begin
                        accum_d = cpu.cpu_write_value;
                     end
                  end else begin
                     rdata_d = '0;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         ACCESS: begin
            // The write strobe registered in IDLE tells store from load
            if (mem_write_enable) begin
               state_d = DONE;
               ready_d = 1'b1;
            end else begin
               state_d = RAM_WAIT;
            end
         end
         RAM_WAIT: begin
            rdata_d = mem_read_value;
            state_d = DONE;
            ready_d = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, plus the two-flop input synchronisers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         ready_q          <= 1'b0;
         err_q            <= 1'b0;
         rdata_q          <= '0;
         mem_address      <= '0;
         mem_write_value  <= '0;
         mem_write_enable <= 1'b0;
         accum_out        <= '0;
         sw_meta          <= '0;
         sw_sync          <= '0;
         btn_meta         <= '0;
         btn_sync         <= '0;
      end else begin
         state_q          <= state_d;
         ready_q          <= ready_d;
         err_q            <= err_d;
         rdata_q          <= rdata_d;
         mem_address      <= maddr_d;
         mem_write_value  <= mwdata_d;
         mem_write_enable <= mwe_d;
         accum_out        <= accum_d;
         sw_meta          <= switches;
         sw_sync          <= sw_meta;
         btn_meta         <= buttons;
         btn_sync         <= btn_meta;
      end
   end

   assign cpu.cpu_ready      = ready_q;
   assign cpu.bus_error      = err_q;
   assign cpu.cpu_read_value = rdata_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed-vector bench for mem_bus_controller: the driver queues expected
// responses, a negedge monitor pops and compares them on every cpu_ready.
module tb_mem_bus_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] mem_address;
   logic [31:0] mem_write_value;
   logic        mem_write_enable;
   logic [31:0] mem_read_value;
   logic [15:0] switches;
   logic [3:0]  buttons;
   logic [31:0] accum_out;

   always #5 clk = ~clk;

   mem_bus_controller_if bus ();

   mem_bus_controller #(.RAM_WORDS(1024), .IO_BASE(20'h01000)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu              (bus),
      .mem_address      (mem_address),
      .mem_write_value  (mem_write_value),
      .mem_write_enable (mem_write_enable),
      .mem_read_value   (mem_read_value),
      .switches         (switches),
      .buttons          (buttons),
      .accum_out        (accum_out)
   );

   // Block RAM model: synchronous write and read, read returns old data
   logic [31:0] ram [0:1023];
   always @(posedge clk) begin
      if (mem_write_enable) ram[mem_address[9:0]] <= mem_write_value;
      mem_read_value <= ram[mem_address[9:0]];
   end

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        chk_data;
      int          lat;
      logic        from_prev;
      logic        chk_acc;
      logic [31:0] acc;
      int          issue;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_ready = 0;
   int          we_cnt = 0;
   logic [19:0] we_addr = '0;
   logic [31:0] we_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor and RAM-strobe tracker
   always @(negedge clk) begin
      if (bus.cpu_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ready: cpu_ready=1 with no request outstanding (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            chk("bus_error", {31'b0, bus.bus_error}, {31'b0, mon_e.err});
            if (mon_e.chk_data) chk("read_value", bus.cpu_read_value, mon_e.data);
            if (mon_e.lat > 0)
               chk("latency", 32'(cyc - (mon_e.from_prev ? last_ready : mon_e.issue)), 32'(mon_e.lat));
            if (mon_e.chk_acc) chk("accum_at_done", accum_out, mon_e.acc);
         end
         last_ready = cyc;
      end
      if (bus.bus_error && !bus.cpu_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL stray_bus_error: bus_error=1 while cpu_ready=0 (t=%0t)", $time);
      end
      if (mem_write_enable) begin
         we_cnt++;
         we_addr = mem_address;
         we_data = mem_write_value;
      end
   end

   task automatic push(input logic [31:0] d, input logic err, input logic chk_d, input int lat,
                       input logic from_prev, input logic chk_acc, input logic [31:0] acc);
      exp_t e;
      e.data = d; e.err = err; e.chk_data = chk_d; e.lat = lat;
      e.from_prev = from_prev; e.chk_acc = chk_acc; e.acc = acc; e.issue = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input string name, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (bus.cpu_ready) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout_%s: no cpu_ready within 20 cycles", name);
         sb.delete();
      end
   endtask

   // One transaction; inputs are scrambled after acceptance to prove they are ignored
   task automatic xfer(input logic we, input logic [19:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_err, input logic chk_d,
                       input int lat, input logic chk_acc, input logic [31:0] acc);
      bit seen;
      push(exp_d, exp_err, chk_d, lat, 1'b0, chk_acc, acc);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_address = a; bus.cpu_write_value = wd;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         bus.cpu_address = ~a; bus.cpu_write_value = ~wd; bus.cpu_we = ~we;
         if (bus.cpu_ready) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout_xfer: addr 0x%05h got no cpu_ready", a);
         sb.delete();
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"},  {31'b0, bus.cpu_ready}, 32'd0);
      chk({tag, "_err"},    {31'b0, bus.bus_error}, 32'd0);
      chk({tag, "_mwe"},    {31'b0, mem_write_enable}, 32'd0);
      chk({tag, "_rdata"},  bus.cpu_read_value, 32'd0);
      chk({tag, "_maddr"},  {12'b0, mem_address}, 32'd0);
      chk({tag, "_mwdata"}, mem_write_value, 32'd0);
      chk({tag, "_accum"},  accum_out, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int w0;
      bit seen;
      for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
      ram[0] = 32'h11;
      ram[1] = 32'h22;
      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_address = '0; bus.cpu_write_value = '0;
      switches = '0; buttons = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      // RAM store then load
      w0 = we_cnt;
      xfer(1'b1, 20'h00100, 32'h12345678, 32'h0, 1'b0, 1'b0, 2, 1'b0, 32'h0);
      chk("ram_store_strobes", 32'(we_cnt - w0), 32'd1);
      chk("ram_store_addr", {12'b0, we_addr}, 32'h00100);
      chk("ram_store_data", we_data, 32'h12345678);
      xfer(1'b0, 20'h00100, 32'h0, 32'h12345678, 1'b0, 1'b1, 3, 1'b0, 32'h0);

      // Switches are read-only
      switches = 16'h00A5;
      repeat (3) @(negedge clk);
      w0 = we_cnt;
      xfer(1'b0, 20'h01000, 32'h0, 32'h000000A5, 1'b0, 1'b1, 1, 1'b0, 32'h0);
      xfer(1'b1, 20'h01000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1, 1'b0, 32'h0);
      xfer(1'b0, 20'h01000, 32'h0, 32'h000000A5, 1'b0, 1'b1, 1, 1'b0, 32'h0);
      chk("io_no_strobe", 32'(we_cnt - w0), 32'd0);

      // Buttons and accumulator
      buttons = 4'b1000;
      repeat (3) @(negedge clk);
      xfer(1'b0, 20'h01001, 32'h0, 32'h00000008, 1'b0, 1'b1, 1, 1'b0, 32'h0);
      xfer(1'b1, 20'h01002, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1, 1'b1, 32'hCAFEF00D);
      xfer(1'b0, 20'h01002, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1, 1'b0, 32'h0);

      // Unmapped accesses and decode boundaries
      w0 = we_cnt;
      xfer(1'b1, 20'h00800, 32'h55, 32'h0, 1'b1, 1'b0, 1, 1'b1, 32'hCAFEF00D);
      xfer(1'b0, 20'h01003, 32'h0, 32'h0, 1'b1, 1'b1, 1, 1'b1, 32'hCAFEF00D);
      xfer(1'b0, 20'h00400, 32'h0, 32'h0, 1'b1, 1'b1, 1, 1'b0, 32'h0);
      xfer(1'b0, 20'h00FFF, 32'h0, 32'h0, 1'b1, 1'b1, 1, 1'b0, 32'h0);
      xfer(1'b1, 20'hFFFFF, 32'h77, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'h0);
      chk("unmapped_no_strobe", 32'(we_cnt - w0), 32'd0);
      chk("unmapped_accum_kept", accum_out, 32'hCAFEF00D);
      xfer(1'b1, 20'h003FF, 32'hA5A55A5A, 32'h0, 1'b0, 1'b0, 2, 1'b0, 32'h0);
      xfer(1'b0, 20'h003FF, 32'h0, 32'hA5A55A5A, 1'b0, 1'b1, 3, 1'b0, 32'h0);

      // Reset while a RAM load sits in RAM_WAIT
      xfer(1'b0, 20'h01000, 32'h0, 32'h000000A5, 1'b0, 1'b1, 1, 1'b0, 32'h0);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 20'h00100;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      xfer(1'b0, 20'h00100, 32'h0, 32'h12345678, 1'b0, 1'b1, 3, 1'b0, 32'h0);

      // cpu_req held across two back-to-back RAM loads
      push(32'h11, 1'b0, 1'b1, 3, 1'b0, 1'b0, 32'h0);
      push(32'h22, 1'b0, 1'b1, 4, 1'b1, 1'b0, 32'h0);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 20'h00000;
      wait_ready("b2b_first", seen);
      bus.cpu_address = 20'h00001;
      if (seen) wait_ready("b2b_second", seen);
      bus.cpu_req = 1'b0;
      repeat (3) @(negedge clk);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
